// File: rtl/ask_slicer_pkg.sv
// Shared types and constants for the adaptive ASK slicer.
package ask_slicer_pkg;

  // Slicer decision states: acquiring levels, locked-low, locked-high.
  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // Default parameter values.
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_WIN_LEN    = 1024;
  localparam int DEF_HYST_SHIFT = 4;
  localparam int DEF_MIN_SPAN   = 4096;
  localparam int DEF_PERIOD_W   = 16;

  // Signed extremes of the default sample width; they seed the running
  // max/min accumulators so a stale value can never look like a level.
  localparam logic signed [DEF_DATA_W-1:0] ENV_SMAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic signed [DEF_DATA_W-1:0] ENV_SMIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage

// File: rtl/env_window_tracker.sv
// Windowed envelope tracker: running max/min over WIN_LEN accepted samples,
// latched at window close together with the threshold, hysteresis and lock.
module env_window_tracker
  import ask_slicer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int HYST_SHIFT = DEF_HYST_SHIFT,
  parameter int MIN_SPAN   = DEF_MIN_SPAN
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_env_max,
  output logic signed [DATA_W-1:0] o_env_min,
  output logic signed [DATA_W-1:0] o_threshold,
  output logic        [DATA_W:0]   o_hyst,
  output logic                     o_locked,
  output logic                     o_close,    // this cycle is an accepted window-closing sample
  output logic                     o_span_ok   // span of the closing window meets MIN_SPAN
);

  localparam int CNT_W = $clog2(WIN_LEN);

  logic        [CNT_W-1:0]  r_wcnt;
  logic signed [DATA_W-1:0] r_acc_max;
  logic signed [DATA_W-1:0] r_acc_min;
  logic signed [DATA_W-1:0] r_env_max;
  logic signed [DATA_W-1:0] r_env_min;
  logic signed [DATA_W-1:0] r_threshold;
  logic        [DATA_W:0]   r_hyst;
  logic                     r_locked;

  logic signed [DATA_W-1:0] w_max_nxt;
  logic signed [DATA_W-1:0] w_min_nxt;
  logic signed [DATA_W:0]   w_max_x;
  logic signed [DATA_W:0]   w_min_x;
  logic signed [DATA_W:0]   w_sum;
  logic        [DATA_W:0]   w_span;
  logic                     w_first;

  // Accumulators including the current sample, plus 33-bit span/sum of them.
  always_comb begin
    w_first   = (r_wcnt == '0);
    w_max_nxt = (w_first || (i_data > r_acc_max)) ? i_data : r_acc_max;
    w_min_nxt = (w_first || (i_data < r_acc_min)) ? i_data : r_acc_min;
    w_max_x   = {w_max_nxt[DATA_W-1], w_max_nxt};
    w_min_x   = {w_min_nxt[DATA_W-1], w_min_nxt};
    w_sum     = w_max_x + w_min_x;
    w_span    = w_max_x - w_min_x;   // max >= min, so the result is non-negative
    o_close   = i_valid && (r_wcnt == CNT_W'(WIN_LEN - 1));
    o_span_ok = (w_span >= (DATA_W+1)'(MIN_SPAN));
  end

  // Window counter, running accumulators and window-close latches.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wcnt      <= '0;
      r_acc_max   <= DATA_W'(ENV_SMIN);
      r_acc_min   <= DATA_W'(ENV_SMAX);
      r_env_max   <= '0;
      r_env_min   <= '0;
      r_threshold <= '0;
      r_hyst      <= '0;
      r_locked    <= 1'b0;
    end else if (i_valid) begin
      r_wcnt    <= r_wcnt + 1'b1;   // power-of-2 window wraps naturally
      r_acc_max <= w_max_nxt;
      r_acc_min <= w_min_nxt;
      if (o_close) begin
        r_env_max   <= w_max_nxt;
        r_env_min   <= w_min_nxt;
        r_threshold <= DATA_W'(w_sum >>> 1);
        r_hyst      <= w_span >> HYST_SHIFT;
        r_locked    <= o_span_ok;
      end
    end
  end

  assign o_env_max   = r_env_max;
  assign o_env_min   = r_env_min;
  assign o_threshold = r_threshold;
  assign o_hyst      = r_hyst;
  assign o_locked    = r_locked;

endmodule

// File: rtl/ask_slicer.sv
// Adaptive ASK bit slicer: hysteresis decision FSM and symbol-period counter
// on top of the windowed envelope tracker.
// Input handshake: s_valid is a one-cycle strobe with no backpressure; a cycle
// with s_valid=1 accepts s_data, every other cycle leaves all state unchanged.
module ask_slicer
  import ask_slicer_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int HYST_SHIFT = DEF_HYST_SHIFT,
  parameter int MIN_SPAN   = DEF_MIN_SPAN,
  parameter int PERIOD_W   = DEF_PERIOD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_valid,
  input  logic signed [DATA_W-1:0] s_data,
  output logic                     ask_bit,
  output logic                     edge_pulse,
  output logic [PERIOD_W-1:0]      sym_period,
  output logic                     period_valid,
  output logic signed [DATA_W-1:0] env_max,
  output logic signed [DATA_W-1:0] env_min,
  output logic signed [DATA_W-1:0] threshold,
  output logic                     locked,
  output logic [1:0]               dbg_state
);

  localparam int CW = DATA_W + 2;   // room for threshold +/- hyst without overflow

  logic [DATA_W:0] w_hyst;
  logic            w_close;
  logic            w_span_ok;

  env_window_tracker #(
    .DATA_W    (DATA_W),
    .WIN_LEN   (WIN_LEN),
    .HYST_SHIFT(HYST_SHIFT),
    .MIN_SPAN  (MIN_SPAN)
  ) u_tracker (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_valid    (s_valid),
    .i_data     (s_data),
    .o_env_max  (env_max),
    .o_env_min  (env_min),
    .o_threshold(threshold),
    .o_hyst     (w_hyst),
    .o_locked   (locked),
    .o_close    (w_close),
    .o_span_ok  (w_span_ok)
  );

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_edge;
  logic                w_force_acq;
  logic                r_ask;
  logic                r_edge;
  logic                r_pv;
  logic                r_first;    // next edge only restarts the period count
  logic [PERIOD_W-1:0] r_pcnt;
  logic [PERIOD_W-1:0] r_period;
  logic [PERIOD_W-1:0] w_pcnt_inc;
  logic signed [CW-1:0] w_s_x;
  logic signed [CW-1:0] w_upper;
  logic signed [CW-1:0] w_lower;

  // Hysteresis bounds from the registered threshold (new window values apply next sample).
  always_comb begin
    w_s_x      = {{2{s_data[DATA_W-1]}}, s_data};
    w_upper    = {{2{threshold[DATA_W-1]}}, threshold} + {1'b0, w_hyst};
    w_lower    = {{2{threshold[DATA_W-1]}}, threshold} - {1'b0, w_hyst};
    w_pcnt_inc = (&r_pcnt) ? r_pcnt : r_pcnt + 1'b1;
  end

  // Next-state logic; a low-span window close overrides any crossing.
  always_comb begin
    w_state_nxt = r_state;
    w_edge      = 1'b0;
    w_force_acq = 1'b0;
    if (s_valid) begin
      if (w_close && !w_span_ok) begin
        w_force_acq = 1'b1;
        w_state_nxt = ST_ACQ;
      end else begin
        case (r_state)
          ST_ACQ:  if (w_close) w_state_nxt = ST_LOW;
          ST_LOW:  if (w_s_x > w_upper) begin
                     w_state_nxt = ST_HIGH;
                     w_edge      = 1'b1;
                   end
          ST_HIGH: if (w_s_x < w_lower) begin
                     w_state_nxt = ST_LOW;
                     w_edge      = 1'b1;
                   end
          default: w_state_nxt = ST_ACQ;
        endcase
      end
    end
  end

  // State register and registered decision outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_ACQ;
      r_ask   <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ask   <= (w_state_nxt == ST_HIGH);
      r_edge  <= w_edge;
    end
  end

  // Saturating sample counter between edges; reports period on each non-first edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pcnt   <= '0;
      r_period <= '0;
      r_pv     <= 1'b0;
      r_first  <= 1'b1;
    end else begin
      r_pv <= 1'b0;
      if (s_valid) begin
        if (w_force_acq) begin
          r_pcnt  <= '0;
          r_first <= 1'b1;
        end else if (w_edge) begin
          r_pcnt  <= '0;
          r_first <= 1'b0;
          if (!r_first) begin
            r_period <= w_pcnt_inc;
            r_pv     <= 1'b1;
          end
        end else begin
          r_pcnt <= w_pcnt_inc;
        end
      end
    end
  end

  assign ask_bit      = r_ask;
  assign edge_pulse   = r_edge;
  assign sym_period   = r_period;
  assign period_valid = r_pv;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_ask_slicer.sv
// Self-checking bench for ask_slicer: vector table with a per-sample
// expected queue, plus hand-written reset sequences.
module tb_ask_slicer;
  import ask_slicer_pkg::*;

  localparam int DW = 32;
  localparam int PW = 16;
  localparam int EW = 22;   // {ask, edge, pv, period[15:0], locked, state[1:0]}

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 s_valid;
  logic signed [DW-1:0] s_data;
  logic                 ask_bit;
  logic                 edge_pulse;
  logic [PW-1:0]        sym_period;
  logic                 period_valid;
  logic signed [DW-1:0] env_max;
  logic signed [DW-1:0] env_min;
  logic signed [DW-1:0] threshold;
  logic                 locked;
  logic [1:0]           dbg_state;

  // Clock / reset block
  always #5 clk = ~clk;

  ask_slicer #(
    .DATA_W(DW), .WIN_LEN(8), .HYST_SHIFT(4), .MIN_SPAN(4096), .PERIOD_W(PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .ask_bit     (ask_bit),
    .edge_pulse  (edge_pulse),
    .sym_period  (sym_period),
    .period_valid(period_valid),
    .env_max     (env_max),
    .env_min     (env_min),
    .threshold   (threshold),
    .locked      (locked),
    .dbg_state   (dbg_state)
  );

  typedef struct {
    logic                 rst_before;
    logic signed [DW-1:0] data;
    logic                 ask;
    logic                 edg;
    logic                 pv;
    logic [PW-1:0]        per;
    logic                 lck;
    logic [1:0]           st;
    logic                 chk_env;
    logic signed [DW-1:0] emax;
    logic signed [DW-1:0] emin;
    logic signed [DW-1:0] thr;
  } vec_t;

  vec_t            vecs[$];
  logic [EW-1:0]   exp_q[$];
  logic            pending_rst = 1'b0;
  int              n_checks = 0;
  int              n_fail   = 0;

  localparam logic [1:0] A = 2'd0;
  localparam logic [1:0] L = 2'd1;
  localparam logic [1:0] H = 2'd2;

  // Scoreboard compare
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Table builders
  function automatic void add(input int n, input logic signed [DW-1:0] d, input logic a,
                              input logic e, input logic p, input logic [PW-1:0] per,
                              input logic l, input logic [1:0] st);
    vec_t v;
    for (int k = 0; k < n; k++) begin
      v = '{rst_before: pending_rst, data: d, ask: a, edg: e, pv: p, per: per,
            lck: l, st: st, chk_env: 1'b0, emax: '0, emin: '0, thr: '0};
      pending_rst = 1'b0;
      vecs.push_back(v);
    end
  endfunction

  function automatic void env(input logic signed [DW-1:0] mx, input logic signed [DW-1:0] mn,
                              input logic signed [DW-1:0] th);
    int i;
    i = vecs.size() - 1;
    vecs[i].chk_env = 1'b1;
    vecs[i].emax    = mx;
    vecs[i].emin    = mn;
    vecs[i].thr     = th;
  endfunction

  // Every output must be zero and the FSM in ACQ
  task automatic check_all_zero(input string tag);
    check({tag, "_bits"}, {ask_bit, edge_pulse, period_valid, sym_period, locked, dbg_state}, '0);
    check({tag, "_env_max"}, env_max, '0);
    check({tag, "_env_min"}, env_min, '0);
    check({tag, "_thr"}, threshold, '0);
  endtask

  // Driver: reset asserted with s_valid toggling, then released
  task automatic reset_seq(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      s_valid = ~s_valid;
      s_data  = $signed($urandom_range(0, 100000));
    end
    #1;
    check_all_zero({tag, "_held"});
    @(negedge clk);
    s_valid = 1'b0;
    reset   = 1'b0;
  endtask

  // Driver: one accepted sample, scoreboard compare, then a random idle gap
  task automatic apply(input int idx, input vec_t v);
    int gap;
    logic [EW-1:0] exp;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = v.data;
    exp_q.push_back({v.ask, v.edg, v.pv, v.per, v.lck, v.st});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    exp = exp_q.pop_front();
    check($sformatf("vec%0d", idx),
          {ask_bit, edge_pulse, period_valid, sym_period, locked, dbg_state}, exp);
    if (v.chk_env) begin
      check($sformatf("vec%0d_env_max", idx), env_max, v.emax);
      check($sformatf("vec%0d_env_min", idx), env_min, v.emin);
      check($sformatf("vec%0d_thr", idx), threshold, v.thr);
    end
    gap = $urandom_range(0, 4);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_gap%0d_pulses", idx, g), {edge_pulse, period_valid}, 2'b00);
    end
  endtask

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;

    // Constant window: no lock, threshold equals the level
    add(8, 1000, 0, 0, 0, 0, 0, A); env(1000, 1000, 1000);
    // Square wave, first window: acquire and lock
    add(4, 0,     0, 0, 0, 0, 0, A);
    add(3, 65536, 0, 0, 0, 0, 0, A);
    add(1, 65536, 0, 0, 0, 0, 1, L); env(65536, 0, 32768);
    // First edge after lock: no period report
    add(4, 0,     0, 0, 0, 0, 1, L);
    add(1, 65536, 1, 1, 0, 0, 1, H);
    add(3, 65536, 1, 0, 0, 0, 1, H); env(65536, 0, 32768);
    // Steady square wave: period 4 on every edge
    add(1, 0,     0, 1, 1, 4, 1, L);
    add(3, 0,     0, 0, 0, 4, 1, L);
    add(1, 65536, 1, 1, 1, 4, 1, H);
    add(3, 65536, 1, 0, 0, 4, 1, H);
    // Inside the hysteresis band: no edge; window span 5000 keeps lock
    for (int k = 0; k < 4; k++) begin
      add(1, 30000, 1, 0, 0, 4, 1, H);
      add(1, 35000, 1, 0, 0, 4, 1, H);
    end
    env(35000, 30000, 32500);
    // Flat window at 0: falls below 32500-312 -> edge with period 12, then loses lock
    add(1, 0, 0, 1, 1, 12, 1, L);
    add(6, 0, 0, 0, 0, 12, 1, L);
    add(1, 0, 0, 0, 0, 12, 0, A); env(0, 0, 0);
    // Relock; first edge after relock gives no period_valid
    add(4, 0,     0, 0, 0, 12, 0, A);
    add(3, 65536, 0, 0, 0, 12, 0, A);
    add(1, 65536, 0, 0, 0, 12, 1, L); env(65536, 0, 32768);
    add(4, 0,     0, 0, 0, 12, 1, L);
    add(1, 65536, 1, 1, 0, 12, 1, H);
    add(3, 65536, 1, 0, 0, 12, 1, H);
    add(1, 0,     0, 1, 1, 4, 1, L);
    add(3, 0,     0, 0, 0, 4, 1, L);
    add(1, 65536, 1, 1, 1, 4, 1, H);   // wcnt 4 of this window; reset follows
    // After reset at wcnt=5: lock only on the 8th further sample
    pending_rst = 1'b1;
    add(4, 0,     0, 0, 0, 0, 0, A);
    add(3, 65536, 0, 0, 0, 0, 0, A);
    add(1, 65536, 0, 0, 0, 0, 1, L); env(65536, 0, 32768);
    add(4, 0,     0, 0, 0, 0, 1, L);
    add(1, 65536, 1, 1, 0, 0, 1, H);

    // Reset held with s_valid toggling, then 20 idle clocks
    reset_seq("por");
    repeat (20) @(posedge clk);
    #1;
    check_all_zero("idle20");

    foreach (vecs[i]) begin
      if (vecs[i].rst_before) reset_seq("midwin");
      apply(i, vecs[i]);
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
